// File: rtl/stall_scoreboard.sv
// Stall scoreboard: per-register result countdowns plus an MDU busy counter.
// Stalls ID while a source is not ready or while the MDU is busy.
module stall_scoreboard #(
    parameter int unsigned NSRC      = 2,
    parameter int unsigned TW        = 2,
    parameter int unsigned MD_CYCLES = 5,
    parameter int unsigned FWD_EN    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [NSRC-1:0]    src_used,
    input  logic [5*NSRC-1:0]  src_addr,
    input  logic [TW*NSRC-1:0] src_tuse,
    input  logic               dst_write,
    input  logic [4:0]         dst_addr,
    input  logic [TW-1:0]      dst_tnew,
    input  logic               md_start,
    input  logic               md_use,
    output logic               stall,
    output logic [31:0]        pending,
    output logic               md_busy
);

    localparam int unsigned MW = $clog2(MD_CYCLES + 1);

    logic [TW-1:0]   count_q [1:31];
    logic [TW-1:0]   count_d [1:31];
    logic [TW-1:0]   count_rd [0:31];
    logic [MW-1:0]   md_q, md_d;
    logic [NSRC-1:0] src_haz;
    logic            md_haz;
    logic            issue;
    logic            load_dst;
    logic [4:0]      rd_addr;
    logic [TW-1:0]   rd_tuse;

    // r0 has no storage; its count always reads zero.
    always_comb begin
        count_rd[0] = '0;
        for (int r = 1; r < 32; r++) begin
            count_rd[r] = count_q[r];
        end
    end

    always_comb begin
        src_haz = '0;
        rd_addr = '0;
        rd_tuse = '0;
        for (int i = 0; i < NSRC; i++) begin
            rd_addr = src_addr[5*i +: 5];
            rd_tuse = src_tuse[TW*i +: TW];
            if (id_valid && src_used[i] && (rd_addr != 5'd0)) begin
                if (FWD_EN != 0) begin
                    src_haz[i] = count_rd[rd_addr] > rd_tuse;
                end else begin
                    src_haz[i] = count_rd[rd_addr] != '0;
                end
            end
        end
    end

    assign md_busy  = (md_q != '0);
    assign md_haz   = id_valid & md_use & md_busy;
    assign stall    = (|src_haz) | md_haz;
    assign issue    = id_valid & ~stall;
    assign load_dst = issue & dst_write & (dst_addr != 5'd0) & (dst_tnew != '0);

    // Youngest writer overwrites the entry, taking priority over the decrement.
    always_comb begin
        for (int r = 1; r < 32; r++) begin
            if (count_q[r] != '0) begin
                count_d[r] = count_q[r] - TW'(1);
            end else begin
                count_d[r] = '0;
            end
            if (load_dst && (dst_addr == 5'(r))) begin
                count_d[r] = dst_tnew;
            end
        end
    end

    always_comb begin
        if (issue && md_start) begin
            md_d = MW'(MD_CYCLES);
        end else if (md_q != '0) begin
            md_d = md_q - MW'(1);
        end else begin
            md_d = md_q;
        end
    end

    always_comb begin
        pending[0] = 1'b0;
        for (int r = 1; r < 32; r++) begin
            pending[r] = (count_q[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 1; r < 32; r++) begin
                count_q[r] <= '0;
            end
            md_q <= '0;
        end else begin
            count_q <= count_d;
            md_q    <= md_d;
        end
    end

endmodule

// File: tb/tb_stall_scoreboard.sv
// Directed bench for stall_scoreboard: stimulus pushes expected outputs into a queue,
// a negedge monitor pops one entry per cycle and compares.
module tb_stall_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [1:0]  src_used;
    logic [9:0]  src_addr;
    logic [3:0]  src_tuse;
    logic        dst_write;
    logic [4:0]  dst_addr;
    logic [1:0]  dst_tnew;
    logic        md_start;
    logic        md_use;
    logic        stall, nf_stall;
    logic [31:0] pending, nf_pending;
    logic        md_busy, nf_md_busy;

    always #5 clk = ~clk;

    stall_scoreboard u_dut (
        .clk      (clk),
        .reset    (reset),
        .id_valid (id_valid),
        .src_used (src_used),
        .src_addr (src_addr),
        .src_tuse (src_tuse),
        .dst_write(dst_write),
        .dst_addr (dst_addr),
        .dst_tnew (dst_tnew),
        .md_start (md_start),
        .md_use   (md_use),
        .stall    (stall),
        .pending  (pending),
        .md_busy  (md_busy)
    );

    stall_scoreboard #(.FWD_EN(0)) u_nofwd (
        .clk      (clk),
        .reset    (reset),
        .id_valid (id_valid),
        .src_used (src_used),
        .src_addr (src_addr),
        .src_tuse (src_tuse),
        .dst_write(dst_write),
        .dst_addr (dst_addr),
        .dst_tnew (dst_tnew),
        .md_start (md_start),
        .md_use   (md_use),
        .stall    (nf_stall),
        .pending  (nf_pending),
        .md_busy  (nf_md_busy)
    );

    typedef struct {
        int          step;
        logic        stall;
        logic [31:0] pend;
        logic        busy;
        logic        chk_nf;
        logic        nf_stall;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   step  = 0;

    function automatic logic [31:0] pb(input int r);
        pb = 32'd1 << r;
    endfunction

    task automatic chk(input string name, input int st, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h exp=%0h", name, st, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stall", e.step, {31'd0, stall}, {31'd0, e.stall});
            chk("pending", e.step, pending, e.pend);
            chk("md_busy", e.step, {31'd0, md_busy}, {31'd0, e.busy});
            if (e.chk_nf) begin
                chk("nofwd_stall", e.step, {31'd0, nf_stall}, {31'd0, e.nf_stall});
                chk("nofwd_pending", e.step, nf_pending, e.pend);
                chk("nofwd_md_busy", e.step, {31'd0, nf_md_busy}, {31'd0, e.busy});
            end
        end
    end

    task automatic drv(input logic v, input logic [1:0] used, input logic [4:0] a0,
                       input logic [4:0] a1, input logic [1:0] t0, input logic [1:0] t1,
                       input logic dw, input logic [4:0] da, input logic [1:0] dt,
                       input logic ms, input logic mu);
        id_valid  = v;
        src_used  = used;
        src_addr  = {a1, a0};
        src_tuse  = {t1, t0};
        dst_write = dw;
        dst_addr  = da;
        dst_tnew  = dt;
        md_start  = ms;
        md_use    = mu;
    endtask

    task automatic idle();
        drv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cyc(input logic s, input logic [31:0] p, input logic b,
                       input logic cn, input logic ns);
        exp_t e;
        e.step     = step;
        e.stall    = s;
        e.pend     = p;
        e.busy     = b;
        e.chk_nf   = cn;
        e.nf_stall = ns;
        q.push_back(e);
        step++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog step=%0d got=timeout exp=finish", step);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        // Held in reset with a hostile issue: nothing may stall or load.
        drv(1, 2'b11, 1, 2, 0, 0, 1, 7, 3, 1, 1);    cyc(0, 0, 0, 1, 0);
        reset = 1'b0;
        // Forwarding vs no-forwarding: producer tnew=2, reader tuse=2.
        drv(1, 2'b00, 0, 0, 0, 0, 1, 3, 2, 0, 0);    cyc(0, 0, 0, 1, 0);
        drv(1, 2'b01, 3, 0, 2, 0, 0, 0, 0, 0, 0);    cyc(0, pb(3), 0, 1, 1);
        cyc(0, pb(3), 0, 1, 1);
        cyc(0, 0, 0, 1, 0);
        // Load-use; the stalled reader's own write must not load until it issues.
        drv(1, 2'b00, 0, 0, 0, 0, 1, 8, 2, 0, 0);    cyc(0, 0, 0, 0, 0);
        drv(1, 2'b01, 8, 0, 1, 0, 1, 10, 1, 0, 0);   cyc(1, pb(8), 0, 0, 0);
        cyc(0, pb(8), 0, 0, 0);
        idle();                                      cyc(0, pb(10), 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // Branch on ALU result, then store data on source 1.
        drv(1, 2'b00, 0, 0, 0, 0, 1, 9, 1, 0, 0);    cyc(0, 0, 0, 0, 0);
        drv(1, 2'b01, 9, 0, 0, 0, 0, 0, 0, 0, 0);    cyc(1, pb(9), 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        drv(1, 2'b00, 0, 0, 0, 0, 1, 9, 1, 0, 0);    cyc(0, 0, 0, 0, 0);
        drv(1, 2'b10, 0, 9, 0, 2, 0, 0, 0, 0, 0);    cyc(0, pb(9), 0, 0, 0);
        idle();                                      cyc(0, 0, 0, 0, 0);
        // r0 never pends; overwrite with a smaller tnew; id_valid=0 never stalls.
        drv(1, 2'b00, 0, 0, 0, 0, 1, 0, 3, 0, 0);    cyc(0, 0, 0, 0, 0);
        idle();                                      cyc(0, 0, 0, 0, 0);
        drv(1, 2'b00, 0, 0, 0, 0, 1, 5, 3, 0, 0);    cyc(0, 0, 0, 0, 0);
        drv(0, 2'b01, 5, 0, 0, 0, 1, 6, 3, 0, 0);    cyc(0, pb(5), 0, 0, 0);
        drv(1, 2'b00, 0, 0, 0, 0, 1, 5, 1, 0, 0);    cyc(0, pb(5), 0, 0, 0);
        idle();                                      cyc(0, pb(5), 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        drv(1, 2'b00, 0, 0, 0, 0, 1, 5, 3, 0, 0);    cyc(0, 0, 0, 0, 0);
        drv(1, 2'b00, 0, 0, 0, 0, 1, 5, 1, 0, 0);    cyc(0, pb(5), 0, 0, 0);
        idle();                                      cyc(0, pb(5), 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // tnew=0 write leaves the entry decrementing.
        drv(1, 2'b00, 0, 0, 0, 0, 1, 5, 3, 0, 0);    cyc(0, 0, 0, 0, 0);
        drv(1, 2'b00, 0, 0, 0, 0, 1, 5, 0, 0, 0);    cyc(0, pb(5), 0, 0, 0);
        idle();                                      cyc(0, pb(5), 0, 0, 0);
        cyc(0, pb(5), 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // mult then back-to-back mult/mflo: stall 5 cycles, no reload while stalled.
        drv(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1);    cyc(0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 0, 1, 0, 0);
        end
        cyc(0, 0, 0, 0, 0);
        // Reset in the middle of a load-use stall with the MDU busy.
        drv(1, 2'b00, 0, 0, 0, 0, 1, 8, 2, 0, 0);    cyc(0, 0, 1, 0, 0);
        drv(1, 2'b01, 8, 0, 1, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;                                cyc(1, pb(8), 1, 0, 0);
        reset = 1'b0;                                cyc(0, 0, 0, 0, 0);
        idle();                                      cyc(0, 0, 0, 0, 0);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain step=%0d got=%0d exp=0", step, q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stall_scoreboard.md
STALL_SCOREBOARD -- requirements
Module: stall_scoreboard

Parameters
REQ-001 The block SHALL have parameter NSRC, default 2, meaning the number of source-operand ports checked per ID instruction.
REQ-002 The block SHALL have parameter TW, default 2, meaning the width of the Tuse and Tnew fields.
REQ-003 The block SHALL have parameter MD_CYCLES, default 5, meaning the number of cycles the multiply/divide unit stays busy after a start.
REQ-004 The block SHALL have parameter FWD_EN, default 1, meaning forwarding is present (1) or absent (0).

Interface
REQ-005 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-007 The block SHALL have port id_valid, input, width 1: the ID stage holds a real instruction.
REQ-008 The block SHALL have port src_used, input, width NSRC: per-source "operand read" flags.
REQ-009 The block SHALL have port src_addr, input, width 5*NSRC: source register numbers, with source i at bits [5i+4:5i].
REQ-010 The block SHALL have port src_tuse, input, width TW*NSRC: cycles from ID until each source is consumed.
REQ-011 The block SHALL have port dst_write, input, width 1: the ID instruction writes a GPR.
REQ-012 The block SHALL have port dst_addr, input, width 5: the destination register number.
REQ-013 The block SHALL have port dst_tnew, input, width TW: cycles from ID issue until the result is forwardable.
REQ-014 The block SHALL have port md_start, input, width 1: the ID instruction starts mult/div.
REQ-015 The block SHALL have port md_use, input, width 1: the ID instruction needs HI/LO or the MDU (mf*/mt*/mult/div).
REQ-016 The block SHALL have port stall, output, width 1: freeze PC and ID, and insert a bubble into EX.
REQ-017 The block SHALL have port pending, output, width 32: bit r is set when register r has a nonzero countdown.
REQ-018 The block SHALL have port md_busy, output, width 1: the MDU countdown is nonzero.

Function
REQ-019 The block SHALL hold one TW-bit countdown per register 1..31; register 0 SHALL have no entry and its count SHALL always read 0.
REQ-020 The block SHALL define issue as id_valid & ~stall, evaluated combinationally in the current cycle.
REQ-021 On each clock edge, every nonzero countdown SHALL decrement by 1 and a zero countdown SHALL stay 0 (no wrap).
REQ-022 On issue with dst_write=1, dst_addr!=0 and dst_tnew!=0, the block SHALL load count[dst_addr] with dst_tnew, and this load SHALL take priority over that entry's decrement in the same cycle.
REQ-023 When the issuing instruction writes a register that already has a nonzero count, the new value SHALL overwrite it (youngest writer wins), even if the new value is smaller.
REQ-024 On issue with dst_tnew=0, or with dst_addr=0, the block SHALL leave all entries to decrement normally.
REQ-025 When stall=1, the block SHALL load no countdown entry and SHALL NOT load the MDU counter.
REQ-026 With FWD_EN=1, source i SHALL raise a hazard when id_valid & src_used[i] & (src_addr[i]!=0) & (count[src_addr[i]] > src_tuse[i]), using an unsigned compare on registered counts.
REQ-027 With FWD_EN=0, source i SHALL raise a hazard under the same conditions as REQ-026 but with the condition count[src_addr[i]] != 0, ignoring Tuse.
REQ-028 The MDU counter SHALL be ceil(log2(MD_CYCLES+1)) bits wide.
REQ-029 On issue with md_start=1, the MDU counter SHALL load MD_CYCLES; otherwise it SHALL decrement when nonzero and saturate at 0.
REQ-030 The block SHALL compute md_busy = (MDU counter != 0).
REQ-031 The block SHALL raise an MDU hazard when id_valid & md_use & md_busy, which also covers back-to-back mult.
REQ-032 The block SHALL drive stall as the OR of all source hazards and the MDU hazard, purely combinationally from registered state and current inputs, with zero-cycle latency.
REQ-033 Stall SHALL be self-clearing: a hazard with count c and Tuse t SHALL deassert after exactly c-t cycles.
REQ-034 The block SHALL drive pending[r] = (count[r] != 0) and pending[0] = 0.
REQ-035 When id_valid=0, the block SHALL force stall=0, and the bubble SHALL issue nothing.

Reset
REQ-036 While reset=1 at a clock edge, the block SHALL clear all countdowns and the MDU counter, overriding any issue in that cycle.
REQ-037 After reset, the block SHALL present pending=0, md_busy=0, and stall=0 for any input combination.
REQ-038 A reset asserted mid-operation SHALL discard all in-flight hazards on the next edge, with no residual stall.

Verification
REQ-039 Load-use: issue lw r8 with tnew=2, then next cycle an add reading r8 with tuse=1 -> stall=1 for exactly 1 cycle, then 0; pending[8] is 1 for 2 cycles.
REQ-040 Branch on an ALU result: issue addu r9 with tnew=1, then beq r9 with tuse=0 -> stall=1 for 1 cycle; the same pair with store data tuse=2 -> no stall.
REQ-041 Register 0 and overwrite: write r0 with tnew=3 -> pending stays 0; write r5 with tnew=3 and, while count=2, issue a write to r5 with tnew=1 -> count=1, pending[5] clears 1 cycle later.
REQ-042 MDU: issue mult (md_start), then mflo the next cycle -> stall=1 for 5 cycles (MD_CYCLES=5), with md_busy falling on the same edge that stall falls.
REQ-043 FWD_EN=0 build: issue addu r3 with tnew=2, then a reader with tuse=2 -> stall=1 for 2 cycles; the same stimulus with FWD_EN=1 -> no stall.
REQ-044 Reset mid-hazard: with lw r8 pending (count=2) and a reader stalled, assert reset for 1 cycle -> the next cycle gives pending=0, stall=0, md_busy=0.
